// File: rtl/control_pipe_if.sv
// Decoder-to-pipeline control bundle: ID control word in, hazard/redirect/forwarding and stage controls out.
// Master is the decoder/fetch side; slave is the control pipeline.
interface control_pipe_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic             id_reg_dst;
    logic             id_jump;
    logic             id_branch;
    logic             id_bne;
    logic             id_mem_read;
    logic             id_mem_to_reg;
    logic             id_mem_write;
    logic             id_alu_src;
    logic             id_reg_write;
    logic [1:0]       id_alu_op;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic [4:0]       id_rd;
    logic             ex_zero;

    logic             stall;
    logic             flush;
    logic [1:0]       pc_sel;
    logic             ex_alu_src;
    logic             ex_reg_dst_unused;
    logic [1:0]       ex_alu_op;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             mem_read;
    logic             mem_write;
    logic             wb_reg_write;
    logic             wb_mem_to_reg;
    logic [4:0]       wb_dst;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_reg_dst, id_jump, id_branch, id_bne, id_mem_read,
               id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write, id_alu_op,
               id_rs, id_rt, id_rd, ex_zero,
        input  stall, flush, pc_sel, ex_alu_src, ex_reg_dst_unused, ex_alu_op,
               fwd_a, fwd_b, mem_read, mem_write, wb_reg_write, wb_mem_to_reg,
               wb_dst, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_reg_dst, id_jump, id_branch, id_bne, id_mem_read,
               id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write, id_alu_op,
               id_rs, id_rt, id_rd, ex_zero,
        output stall, flush, pc_sel, ex_alu_src, ex_reg_dst_unused, ex_alu_op,
               fwd_a, fwd_b, mem_read, mem_write, wb_reg_write, wb_mem_to_reg,
               wb_dst, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/control_pipe.sv
// MIPS control pipeline ID->EX->MEM->WB: EX +1, MEM +2, WB +3 cycles; stall/flush/fwd are combinational.
// Backpressure: stall holds upstream PC/IF-ID and drops a bubble into EX; flush kills IF/ID and bubbles EX.
module control_pipe #(
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    control_pipe_if.slave bus
);

    typedef struct packed {
        logic       valid;
        logic       jump;
        logic       branch;
        logic       bne;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic [1:0] alu_op;
        logic [4:0] dst;
        logic [4:0] rs;
        logic [4:0] rt;
    } ex_t;

    typedef struct packed {
        logic       valid;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic [4:0] dst;
    } mem_t;

    typedef struct packed {
        logic       valid;
        logic       mem_to_reg;
        logic       reg_write;
        logic [4:0] dst;
    } wb_t;

    ex_t              id_word;
    ex_t              ex_q;
    mem_t             mem_d;
    mem_t             mem_q;
    wb_t              wb_d;
    wb_t              wb_q;
    logic [4:0]       id_dst;
    logic             uses_rt;
    logic             load_use;
    logic             br_taken;
    logic             jmp;
    logic             redirect;
    logic             bubble;
    logic             stall_int;
    logic             mem_fwd_ok;
    logic             wb_fwd_ok;
    logic [1:0]       fwd_a_int;
    logic [1:0]       fwd_b_int;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // $zero is never a real destination, so its write enable is dropped here once.
    always_comb begin
        id_dst             = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
        id_word            = '0;
        id_word.valid      = bus.id_valid;
        id_word.jump       = bus.id_jump;
        id_word.branch     = bus.id_branch;
        id_word.bne        = bus.id_bne;
        id_word.mem_read   = bus.id_mem_read;
        id_word.mem_to_reg = bus.id_mem_to_reg;
        id_word.mem_write  = bus.id_mem_write;
        id_word.alu_src    = bus.id_alu_src;
        id_word.reg_write  = bus.id_reg_write & (id_dst != 5'd0);
        id_word.alu_op     = bus.id_alu_op;
        id_word.dst        = id_dst;
        id_word.rs         = bus.id_rs;
        id_word.rt         = bus.id_rt;
    end

    assign uses_rt  = ~bus.id_alu_src | bus.id_mem_write;
    assign load_use = ex_q.valid & ex_q.mem_read & ex_q.reg_write & bus.id_valid &
                      ((ex_q.dst == bus.id_rs) | (uses_rt & (ex_q.dst == bus.id_rt)));

    assign br_taken  = ex_q.valid & ((ex_q.branch & bus.ex_zero) | (ex_q.bne & ~bus.ex_zero));
    assign jmp       = ex_q.valid & ex_q.jump;
    assign redirect  = br_taken | jmp;
    // A redirect kills the instruction in ID, so any hazard it had is moot.
    assign stall_int = load_use & ~redirect;
    assign bubble    = load_use | redirect;

    always_comb begin
        mem_d            = '0;
        mem_d.valid      = ex_q.valid;
        mem_d.mem_read   = ex_q.mem_read;
        mem_d.mem_write  = ex_q.mem_write;
        mem_d.mem_to_reg = ex_q.mem_to_reg;
        mem_d.reg_write  = ex_q.reg_write;
        mem_d.dst        = ex_q.dst;
        wb_d             = '0;
        wb_d.valid       = mem_q.valid;
        wb_d.mem_to_reg  = mem_q.mem_to_reg;
        wb_d.reg_write   = mem_q.reg_write;
        wb_d.dst         = mem_q.dst;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q  <= bubble ? ex_t'('0) : id_word;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            if (stall_int && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (redirect && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    // The younger producer (MEM) wins over WB when both target the same register.
    assign mem_fwd_ok = mem_q.valid & mem_q.reg_write;
    assign wb_fwd_ok  = wb_q.valid & wb_q.reg_write;

    always_comb begin
        fwd_a_int = 2'b00;
        if (mem_fwd_ok && (mem_q.dst == ex_q.rs)) begin
            fwd_a_int = 2'b10;
        end else if (wb_fwd_ok && (wb_q.dst == ex_q.rs)) begin
            fwd_a_int = 2'b01;
        end
        fwd_b_int = 2'b00;
        if (mem_fwd_ok && (mem_q.dst == ex_q.rt)) begin
            fwd_b_int = 2'b10;
        end else if (wb_fwd_ok && (wb_q.dst == ex_q.rt)) begin
            fwd_b_int = 2'b01;
        end
    end

    assign bus.stall             = stall_int;
    assign bus.flush             = redirect;
    assign bus.pc_sel            = jmp ? 2'b10 : (br_taken ? 2'b01 : 2'b00);
    assign bus.fwd_a             = fwd_a_int;
    assign bus.fwd_b             = fwd_b_int;
    assign bus.ex_alu_src        = ex_q.valid & ex_q.alu_src;
    assign bus.ex_reg_dst_unused = 1'b0;
    assign bus.ex_alu_op         = ex_q.alu_op & {2{ex_q.valid}};
    assign bus.mem_read          = mem_q.valid & mem_q.mem_read;
    assign bus.mem_write         = mem_q.valid & mem_q.mem_write;
    assign bus.wb_reg_write      = wb_q.valid & wb_q.reg_write;
    assign bus.wb_mem_to_reg     = wb_q.valid & wb_q.mem_to_reg;
    assign bus.wb_dst            = wb_q.dst & {5{wb_q.valid}};
    assign bus.stall_cnt         = stall_cnt_q;
    assign bus.flush_cnt         = flush_cnt_q;

endmodule

// File: tb/tb_control_pipe.sv
// Scenario bench for control_pipe with 4-bit counters; WB results are scoreboarded in issue order.
module tb_control_pipe;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    control_pipe_if #(.CNT_W(4)) bus ();
    control_pipe #(.CNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct packed {
        logic       valid;
        logic       reg_dst;
        logic       jump;
        logic       branch;
        logic       bne;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic [1:0] alu_op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
    } ins_t;

    typedef struct packed {
        logic       rw;
        logic       m2r;
        logic [4:0] dst;
    } wb_exp_t;

    wb_exp_t sb[$];
    wb_exp_t exp_wb;
    wb_exp_t got_wb;

    logic [28:0] outs;
    assign outs = {bus.stall, bus.flush, bus.pc_sel, bus.fwd_a, bus.fwd_b, bus.ex_alu_src,
                   bus.ex_reg_dst_unused, bus.ex_alu_op, bus.mem_read, bus.mem_write,
                   bus.wb_reg_write, bus.wb_mem_to_reg, bus.wb_dst, bus.stall_cnt, bus.flush_cnt};
    assign got_wb = {bus.wb_reg_write, bus.wb_mem_to_reg, bus.wb_dst};

    localparam ins_t NOP = '0;

    function automatic ins_t mk_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        ins_t i = '0;
        i.valid = 1'b1; i.reg_dst = 1'b1; i.reg_write = 1'b1; i.alu_op = 2'b10;
        i.rs = rs; i.rt = rt; i.rd = rd;
        return i;
    endfunction

    function automatic ins_t mk_lw(input logic [4:0] rs, input logic [4:0] rt);
        ins_t i = '0;
        i.valid = 1'b1; i.alu_src = 1'b1; i.mem_read = 1'b1; i.mem_to_reg = 1'b1;
        i.reg_write = 1'b1; i.rs = rs; i.rt = rt;
        return i;
    endfunction

    function automatic ins_t mk_sw(input logic [4:0] rs, input logic [4:0] rt);
        ins_t i = '0;
        i.valid = 1'b1; i.alu_src = 1'b1; i.mem_write = 1'b1; i.rs = rs; i.rt = rt;
        return i;
    endfunction

    function automatic ins_t mk_addi(input logic [4:0] rs, input logic [4:0] rt);
        ins_t i = '0;
        i.valid = 1'b1; i.alu_src = 1'b1; i.reg_write = 1'b1; i.rs = rs; i.rt = rt;
        return i;
    endfunction

    function automatic ins_t mk_j();
        ins_t i = '0;
        i.valid = 1'b1; i.jump = 1'b1;
        return i;
    endfunction

    task automatic drive(input ins_t i);
        bus.id_valid      = i.valid;
        bus.id_reg_dst    = i.reg_dst;
        bus.id_jump       = i.jump;
        bus.id_branch     = i.branch;
        bus.id_bne        = i.bne;
        bus.id_mem_read   = i.mem_read;
        bus.id_mem_to_reg = i.mem_to_reg;
        bus.id_mem_write  = i.mem_write;
        bus.id_alu_src    = i.alu_src;
        bus.id_reg_write  = i.reg_write;
        bus.id_alu_op     = i.alu_op;
        bus.id_rs         = i.rs;
        bus.id_rt         = i.rt;
        bus.id_rd         = i.rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(NOP);
        bus.ex_zero = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        sb.delete();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (outs !== 29'd0) begin
            errors++; $display("FAIL reset_outs: got %h expected 0", outs);
        end
        tick();
        checks++;
        if (outs !== 29'd0) begin
            errors++; $display("FAIL reset_idle: got %h expected 0", outs);
        end
    endtask

    task automatic test_rtype();
        do_reset();
        drive(mk_r(5'd1, 5'd2, 5'd5));
        sb.push_back('{1'b1, 1'b0, 5'd5});
        tick();
        drive(NOP);
        #1;
        checks++;
        if (bus.ex_alu_op !== 2'b10) begin
            errors++; $display("FAIL rtype_ex_alu_op: got %b expected 10", bus.ex_alu_op);
        end
        tick();
        checks++;
        if ({bus.mem_read, bus.mem_write} !== 2'b00) begin
            errors++; $display("FAIL rtype_mem: got %b expected 00", {bus.mem_read, bus.mem_write});
        end
        tick();
        exp_wb = sb.pop_front();
        checks++;
        if (got_wb !== exp_wb) begin
            errors++; $display("FAIL rtype_wb: got %h expected %h", got_wb, exp_wb);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(mk_lw(5'd1, 5'd8));
        sb.push_back('{1'b1, 1'b1, 5'd8});
        tick();
        drive(mk_r(5'd8, 5'd2, 5'd9));
        sb.push_back('{1'b0, 1'b0, 5'd0});
        sb.push_back('{1'b1, 1'b0, 5'd9});
        #1;
        checks++;
        if ({bus.stall, bus.flush} !== 2'b10) begin
            errors++; $display("FAIL lu_stall: got stall/flush %b expected 10", {bus.stall, bus.flush});
        end
        tick();
        checks++;
        if ({bus.stall, bus.ex_alu_op, bus.mem_read} !== 4'b0001) begin
            errors++; $display("FAIL lu_bubble: got %b expected 0001", {bus.stall, bus.ex_alu_op, bus.mem_read});
        end
        tick();
        drive(NOP);
        #1;
        checks++;
        if ({bus.fwd_a, bus.fwd_b, bus.ex_alu_op} !== 6'b010010) begin
            errors++; $display("FAIL lu_fwd: got %b expected 010010", {bus.fwd_a, bus.fwd_b, bus.ex_alu_op});
        end
        checks++;
        if (bus.stall_cnt !== 4'd1) begin
            errors++; $display("FAIL lu_stall_cnt: got %0d expected 1", bus.stall_cnt);
        end
        for (int k = 0; k < 3; k++) begin
            exp_wb = sb.pop_front();
            checks++;
            if (got_wb !== exp_wb) begin
                errors++; $display("FAIL lu_wb%0d: got %h expected %h", k, got_wb, exp_wb);
            end
            tick();
        end
    endtask

    task automatic test_branch_priority();
        ins_t x;
        do_reset();
        x = '0;
        x.valid = 1'b1; x.branch = 1'b1; x.mem_read = 1'b1; x.reg_write = 1'b1;
        x.alu_op = 2'b01; x.rs = 5'd1; x.rt = 5'd7;
        drive(x);
        sb.push_back('{1'b1, 1'b0, 5'd7});
        tick();
        bus.ex_zero = 1'b1;
        drive(mk_r(5'd7, 5'd2, 5'd10));
        sb.push_back('{1'b0, 1'b0, 5'd0});
        #1;
        checks++;
        if ({bus.flush, bus.stall, bus.pc_sel} !== 4'b1001) begin
            errors++; $display("FAIL beq_redirect: got %b expected 1001", {bus.flush, bus.stall, bus.pc_sel});
        end
        tick();
        drive(NOP);
        bus.ex_zero = 1'b0;
        #1;
        checks++;
        if ({bus.ex_alu_op, bus.mem_read, bus.flush_cnt, bus.stall_cnt} !== 11'b00_1_0001_0000) begin
            errors++; $display("FAIL beq_after: got %b expected 00100010000",
                               {bus.ex_alu_op, bus.mem_read, bus.flush_cnt, bus.stall_cnt});
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            exp_wb = sb.pop_front();
            checks++;
            if (got_wb !== exp_wb) begin
                errors++; $display("FAIL beq_wb%0d: got %h expected %h", k, got_wb, exp_wb);
            end
            tick();
        end

        do_reset();
        x.branch = 1'b0; x.bne = 1'b1;
        drive(x);
        tick();
        bus.ex_zero = 1'b1;
        drive(mk_r(5'd7, 5'd2, 5'd10));
        #1;
        checks++;
        if ({bus.flush, bus.stall, bus.pc_sel} !== 4'b0100) begin
            errors++; $display("FAIL bne_no_redirect: got %b expected 0100", {bus.flush, bus.stall, bus.pc_sel});
        end
        tick();
        drive(NOP);
        bus.ex_zero = 1'b0;
        #1;
        checks++;
        if ({bus.flush_cnt, bus.stall_cnt} !== 8'h01) begin
            errors++; $display("FAIL bne_counts: got %h expected 01", {bus.flush_cnt, bus.stall_cnt});
        end
    endtask

    task automatic test_jump();
        do_reset();
        drive(mk_j());
        tick();
        drive(mk_sw(5'd1, 5'd2));
        #1;
        checks++;
        if ({bus.flush, bus.pc_sel} !== 3'b110) begin
            errors++; $display("FAIL j_redirect: got %b expected 110", {bus.flush, bus.pc_sel});
        end
        tick();
        drive(NOP);
        #1;
        checks++;
        if ({bus.flush, bus.flush_cnt} !== 5'b0_0001) begin
            errors++; $display("FAIL j_flush_cnt: got %b expected 00001", {bus.flush, bus.flush_cnt});
        end
        tick();
        checks++;
        if (bus.mem_write !== 1'b0) begin
            errors++; $display("FAIL j_killed_sw: got mem_write %b expected 0", bus.mem_write);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(mk_addi(5'd1, 5'd3));
        sb.push_back('{1'b1, 1'b0, 5'd3});
        tick();
        drive(mk_r(5'd3, 5'd3, 5'd4));
        sb.push_back('{1'b1, 1'b0, 5'd4});
        tick();
        drive(mk_addi(5'd1, 5'd0));
        sb.push_back('{1'b0, 1'b0, 5'd0});
        #1;
        checks++;
        if ({bus.fwd_a, bus.fwd_b} !== 4'b1010) begin
            errors++; $display("FAIL b2b_fwd: got %b expected 1010", {bus.fwd_a, bus.fwd_b});
        end
        tick();
        drive(mk_r(5'd0, 5'd0, 5'd6));
        exp_wb = sb.pop_front();
        checks++;
        if (got_wb !== exp_wb) begin
            errors++; $display("FAIL b2b_wb_addi: got %h expected %h", got_wb, exp_wb);
        end
        tick();
        drive(NOP);
        #1;
        checks++;
        if ({bus.fwd_a, bus.fwd_b} !== 4'b0000) begin
            errors++; $display("FAIL zero_no_fwd: got %b expected 0000", {bus.fwd_a, bus.fwd_b});
        end
        for (int k = 0; k < 2; k++) begin
            exp_wb = sb.pop_front();
            checks++;
            if (got_wb !== exp_wb) begin
                errors++; $display("FAIL b2b_wb%0d: got %h expected %h", k, got_wb, exp_wb);
            end
            tick();
        end
    endtask

    task automatic test_fwd_priority();
        do_reset();
        drive(mk_addi(5'd1, 5'd3));
        tick();
        drive(mk_addi(5'd2, 5'd3));
        tick();
        drive(mk_r(5'd3, 5'd5, 5'd6));
        tick();
        drive(NOP);
        #1;
        checks++;
        if ({bus.fwd_a, bus.fwd_b} !== 4'b1000) begin
            errors++; $display("FAIL fwd_mem_over_wb: got %b expected 1000", {bus.fwd_a, bus.fwd_b});
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(mk_lw(5'd1, 5'd8));
            tick();
            drive(mk_r(5'd8, 5'd2, 5'd9));
            tick();
            tick();
            if (i == 9) begin
                checks++;
                if (bus.stall_cnt !== 4'd10) begin
                    errors++; $display("FAIL sat_mid: got %0d expected 10", bus.stall_cnt);
                end
            end
        end
        drive(NOP);
        #1;
        checks++;
        if (bus.stall_cnt !== 4'd15) begin
            errors++; $display("FAIL sat_hold: got %0d expected 15", bus.stall_cnt);
        end
    endtask

    task automatic test_reset_mid();
        drive(mk_addi(5'd1, 5'd3));
        tick();
        drive(mk_r(5'd3, 5'd3, 5'd4));
        tick();
        drive(mk_j());
        rst_n = 1'b0;
        tick();
        checks++;
        if (outs !== 29'd0) begin
            errors++; $display("FAIL reset_mid: got %h expected 0", outs);
        end
        rst_n = 1'b1;
        drive(NOP);
        tick();
        checks++;
        if ({bus.flush, bus.pc_sel, bus.ex_alu_op} !== 5'd0) begin
            errors++; $display("FAIL reset_mid_no_redirect: got %b expected 00000",
                               {bus.flush, bus.pc_sel, bus.ex_alu_op});
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(NOP);
        bus.ex_zero = 1'b0;
        test_reset();
        test_rtype();
        test_load_use();
        test_branch_priority();
        test_jump();
        test_back_to_back();
        test_fwd_priority();
        test_saturation();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
